pwm_axil_regs: RTL and testbench

AXI4-Lite responder and PWM generator that sits behind the S00_AXI port of the PWM IP and is driven by the master VIP in the block-design bench. It decodes four 32-bit registers, acknowledges every transfer with OKAY, and uses the register contents to run a prescaled PWM counter. Period and duty are double-buffered so that a mid-period register write never produces a glitch on the output.

---
 rtl/pwm_axil_regs.sv | 168 ++++++++++++++++
 tb/tb_pwm_axil_regs.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_axil_regs.sv
// pwm_axil_regs -- AXI4-Lite register slave with a double-buffered PWM engine.
//
// Registers (decoded on address bits [3:2], bits [1:0] ignored, WSTRB per byte):
//   0x0 CTRL     bit0 EN, bit1 IRQ_EN, bit2 INV (bits [31:3] stored only)
//   0x4 PERIOD   ticks per PWM cycle
//   0x8 DUTY     high ticks per PWM cycle
//   0xC PRESCALE one tick every PRESCALE+1 clocks
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN (synchronous, active-low)
//   S_AXI_AW*/W*/B*           write address, data and response channels
//   S_AXI_AR*/R*              read address and data channels
//   pwm_out                   registered PWM waveform
//   pwm_irq                   one-cycle pulse per period wrap
//
// Build option: define PWM_IRQ_EN to generate pwm_irq; otherwise it is tied
// to 0 and the IRQ_EN bit is only stored.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. AWREADY/WREADY are high together only while AWVALID, WVALID
// are both high and no write response is pending; ARREADY is high while
// ARVALID is high and no read data is pending. BVALID/RVALID, once raised,
// hold (with BRESP/RRESP/RDATA stable) until the edge where BREADY/RREADY is
// high.
module pwm_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              pwm_out,
  output logic                              pwm_irq
);

  logic [3:0][31:0] regs;
  logic             live;      // low for the cycle after a reset edge, gates READYs
  logic             bvalid_q;
  logic             rvalid_q;
  logic [31:0]      rdata_q;
  logic             wr_acc;
  logic             rd_acc;
  logic [1:0]       widx;
  logic [1:0]       ridx;

  assign widx   = S_AXI_AWADDR[3:2];
  assign ridx   = S_AXI_ARADDR[3:2];
  assign wr_acc = live && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
  assign rd_acc = live && S_AXI_ARVALID && !rvalid_q;

  assign S_AXI_AWREADY = wr_acc;
  assign S_AXI_WREADY  = wr_acc;
  assign S_AXI_ARREADY = rd_acc;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;

  // Register file and both AXI channels.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      regs     <= '0;
      live     <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      live <= 1'b1;
      if (wr_acc) begin
        for (int b = 0; b < 4; b++) begin
          if (S_AXI_WSTRB[b]) regs[widx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
        bvalid_q <= 1'b1;
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      // Captured before this edge's write lands, so a same-cycle read of the
      // written register returns the old value.
      if (rd_acc) begin
        rdata_q  <= regs[ridx];
        rvalid_q <= 1'b1;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // PWM engine
  logic        en, irq_en, inv;
  logic [31:0] pcnt, cnt, period_s, duty_s;
  logic        pwm_q;
  logic        tick, wrap;

  assign en     = regs[0][0];
  assign irq_en = regs[0][1];
  assign inv    = regs[0][2];

  // >= keeps the prescaler from running away if PRESCALE shrinks mid-count.
  assign tick = (pcnt >= regs[3]);
  // With period_s = 0 every tick counts as a wrap so the shadows keep
  // reloading and a new PERIOD can still take effect.
  assign wrap = tick && ((period_s == 32'd0) || (cnt == period_s - 32'd1));

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      pcnt     <= '0;
      cnt      <= '0;
      period_s <= '0;
      duty_s   <= '0;
      pwm_q    <= 1'b0;
    end else if (!en) begin
      pcnt     <= '0;
      cnt      <= '0;
      period_s <= regs[1];
      duty_s   <= regs[2];
      pwm_q    <= inv;
    end else begin
      pcnt <= tick ? 32'd0 : pcnt + 32'd1;
      if (wrap) begin
        cnt      <= '0;
        period_s <= regs[1];
        duty_s   <= regs[2];
      end else if (tick) begin
        cnt <= cnt + 32'd1;
      end
      // Shadows only change at a wrap, so cnt < period_s always holds and
      // duty_s >= period_s gives a constant high.
      pwm_q <= ((period_s != 32'd0) && (cnt < duty_s)) ^ inv;
    end
  end

  assign pwm_out = pwm_q;

`ifdef PWM_IRQ_EN
  logic irq_q;
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) irq_q <= 1'b0;
    else                irq_q <= en && irq_en && wrap && (period_s != 32'd0);
  end
  assign pwm_irq = irq_q;
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
  assign pwm_irq = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], irq_en};
`endif

endmodule

// File: tb/tb_pwm_axil_regs.sv
// Bench for pwm_axil_regs: directed AXI-Lite transfers, a clock-level
// behavioural model of the register file and PWM waveform, and a per-cycle
// compare of pwm_out/pwm_irq against that model.
module tb_pwm_axil_regs;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        pwm_out, pwm_irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_axil_regs dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rstn),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .pwm_out       (pwm_out),
    .pwm_irq       (pwm_irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no handshake within 20 cycles, expected one", name);
  endtask

  // ---------------- behavioural model ----------------
  // Register mirror plus the waveform described as "clocks into the current
  // period": each tick lasts PRESCALE+1 clocks, a period lasts PERIOD ticks.
  logic [31:0] m_reg [4];
  logic [31:0] m_ps, m_ds;
  longint      m_clk;
  logic        m_exp_pwm, m_exp_irq;
  bit          m_valid = 0;
  bit          mw_pend = 0;
  logic [1:0]  mw_idx;
  logic [31:0] mw_data;
  logic [3:0]  mw_strb;

  always @(posedge clk) begin : model
    longint per_tick, len, idx;
    logic   m_en, m_irqen, m_inv;
    if (!rstn) begin
      for (int i = 0; i < 4; i++) m_reg[i] = 32'd0;
      m_ps = 0; m_ds = 0; m_clk = 0;
      m_exp_pwm = 0; m_exp_irq = 0;
      m_valid = 1;
    end else begin
      m_en = m_reg[0][0]; m_irqen = m_reg[0][1]; m_inv = m_reg[0][2];
      m_exp_irq = 0;
      if (!m_en) begin
        m_ps = m_reg[1]; m_ds = m_reg[2]; m_clk = 0;
        m_exp_pwm = m_inv;
      end else begin
        per_tick  = longint'(m_reg[3]) + 1;
        idx       = m_clk / per_tick;
        m_exp_pwm = ((m_ps != 0) && (idx < longint'(m_ds))) ^ m_inv;
        len       = ((m_ps == 0) ? 64'd1 : longint'(m_ps)) * per_tick;
        if (m_clk + 1 == len) begin
          m_exp_irq = m_irqen && (m_ps != 0);
          m_clk = 0; m_ps = m_reg[1]; m_ds = m_reg[2];
        end else begin
          m_clk = m_clk + 1;
        end
      end
      if (mw_pend) begin
        for (int b = 0; b < 4; b++)
          if (mw_strb[b]) m_reg[mw_idx][8*b +: 8] = mw_data[8*b +: 8];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("pwm_out", {31'd0, pwm_out}, {31'd0, m_exp_pwm});
`ifdef PWM_IRQ_EN
      check("pwm_irq", {31'd0, pwm_irq}, {31'd0, m_exp_irq});
`else
      check("pwm_irq", {31'd0, pwm_irq}, 32'd0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb = 4'hF);
    int t = 0;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1;
    #1;
    while (!(awready && wready) && t < 20) begin @(negedge clk); #1; t++; end
    if (t >= 20) begin
      fail_timeout("write_handshake");
      awvalid = 0; wvalid = 0;
      return;
    end
    mw_pend = 1; mw_idx = addr[3:2]; mw_data = data; mw_strb = strb;
    @(posedge clk);
    @(negedge clk);
    awvalid = 0; wvalid = 0; mw_pend = 0;
    check("bvalid_after_write", {31'd0, bvalid}, 32'd1);
    check("bresp", {30'd0, bresp}, 32'd0);
    bready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0;
    check("bvalid_cleared", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int t = 0;
    data = 32'hDEAD_BEEF;
    @(negedge clk);
    araddr = addr; arvalid = 1; rready = 1;
    #1;
    while (!arready && t < 20) begin @(negedge clk); #1; t++; end
    if (t >= 20) begin
      fail_timeout("read_handshake");
      arvalid = 0; rready = 0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    arvalid = 0;
    check("rvalid_after_read", {31'd0, rvalid}, 32'd1);
    check("rresp", {30'd0, rresp}, 32'd0);
    data = rdata;
    @(posedge clk);
    @(negedge clk);
    rready = 0;
    check("rvalid_cleared", {31'd0, rvalid}, 32'd0);
  endtask

  task automatic read_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(addr, d);
    check(name, d, exp);
    check({name, "_model"}, d, m_reg[addr[3:2]]);
  endtask

  task automatic count_window(input int n, output int hi, output int irqs);
    hi = 0; irqs = 0;
    repeat (n) begin
      @(negedge clk);
      hi += int'(pwm_out);
      irqs += int'(pwm_irq);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int hi, irqs, bad;
    rstn = 0; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = 0; wstrb = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid",  {31'd0, bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_rdata",   rdata,            32'd0);
    check("rst_pwm_out", {31'd0, pwm_out}, 32'd0);
    rstn = 1;

    // Register readback, including ignored low address bits.
    axi_write(4'h0, 32'h1);
    axi_write(4'h4, 32'h2);
    axi_write(4'hA, 32'h3);
    axi_write(4'hC, 32'h4);
    read_check("rd_ctrl",     4'h0, 32'h1);
    read_check("rd_period",   4'h4, 32'h2);
    read_check("rd_duty",     4'hB, 32'h3);
    read_check("rd_prescale", 4'hC, 32'h4);

    // Byte strobes: bytes 0 and 2 only.
    axi_write(4'h8, 32'hAABB_CCDD, 4'b0101);
    read_check("rd_strobe", 4'h8, 32'h00BB_00DD);

    // PERIOD=4 DUTY=1 PRESCALE=0: 1 high / 3 low, then inverted.
    axi_write(4'h0, 32'h0);
    axi_write(4'h4, 32'd4);
    axi_write(4'h8, 32'd1);
    axi_write(4'hC, 32'd0);
    axi_write(4'h0, 32'h1);
    repeat (8) @(negedge clk);
    count_window(16, hi, irqs);
    check("duty1_high_count", hi, 32'd4);
    axi_write(4'h0, 32'h5);
    repeat (8) @(negedge clk);
    count_window(16, hi, irqs);
    check("duty1_inv_high_count", hi, 32'd12);

    // PRESCALE=1, DUTY=3: 6 high / 2 low; then DUTY=1 mid-period.
    axi_write(4'h0, 32'h0);
    axi_write(4'hC, 32'd1);
    axi_write(4'h8, 32'd3);
    axi_write(4'h0, 32'h1);
    repeat (10) @(negedge clk);
    count_window(16, hi, irqs);
    check("pre1_duty3_high_count", hi, 32'd12);
    repeat (3) @(negedge clk);
    axi_write(4'h8, 32'd1);
    repeat (16) @(negedge clk);
    count_window(16, hi, irqs);
    check("pre1_duty1_high_count", hi, 32'd4);

    // Boundaries: duty >= period, duty 0, period 0.
    axi_write(4'h0, 32'h0);
    axi_write(4'hC, 32'd0);
    axi_write(4'h4, 32'd8);
    axi_write(4'h8, 32'hFFFF_FFFF);
    axi_write(4'h0, 32'h1);
    repeat (10) @(negedge clk);
    count_window(16, hi, irqs);
    check("duty_max_high_count", hi, 32'd16);
    axi_write(4'h8, 32'd0);
    repeat (16) @(negedge clk);
    count_window(16, hi, irqs);
    check("duty_zero_high_count", hi, 32'd0);
    axi_write(4'h8, 32'd3);
    axi_write(4'h4, 32'd0);
    repeat (16) @(negedge clk);
    count_window(16, hi, irqs);
    check("period_zero_high_count", hi, 32'd0);

    // AW without W must wait.
    @(negedge clk);
    awaddr = 4'h8; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 0;
    bad = 0;
    repeat (10) begin
      #1;
      if (awready || wready) bad++;
      @(negedge clk);
    end
    check("aw_without_w_ready", bad, 32'd0);
    read_check("rd_duty_unchanged", 4'h8, 32'd3);
    @(negedge clk);
    wvalid = 1;
    #1;
    check("aw_w_ready_pulse", {30'd0, awready, wready}, 32'd3);
    mw_pend = 1; mw_idx = 2'd2; mw_data = 32'h55; mw_strb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    awvalid = 0; wvalid = 0; mw_pend = 0;
    check("bvalid_next_cycle", {31'd0, bvalid}, 32'd1);
    check("awready_one_cycle", {31'd0, awready}, 32'd0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bvalid !== 1'b1) bad++;
    end
    check("bvalid_held", bad, 32'd0);
    bready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0;
    check("bvalid_released", {31'd0, bvalid}, 32'd0);
    read_check("rd_duty_written", 4'h8, 32'h55);

    // IRQ: CTRL=3, PERIOD=4, PRESCALE=0, DUTY=3.
    axi_write(4'h0, 32'h0);
    axi_write(4'h8, 32'd3);
    axi_write(4'h4, 32'd4);
    axi_write(4'h0, 32'h3);
    repeat (10) @(negedge clk);
    count_window(16, hi, irqs);
    check("irq_duty3_high_count", hi, 32'd12);
`ifdef PWM_IRQ_EN
    check("irq_pulse_count", irqs, 32'd4);
`else
    check("irq_pulse_count", irqs, 32'd0);
`endif

    // Reset during a pending read response.
    @(negedge clk);
    araddr = 4'h4; arvalid = 1; rready = 0;
    #1;
    check("arready_mid_read", {31'd0, arready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 0;
    check("rvalid_pending", {31'd0, rvalid}, 32'd1);
    @(negedge clk);
    check("rdata_held", rdata, 32'd4);
    rstn = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_mid_rdata",   rdata,            32'd0);
    check("rst_mid_pwm_out", {31'd0, pwm_out}, 32'd0);
    rstn = 1;
    read_check("rd_period_after_rst", 4'h4, 32'd0);
    read_check("rd_ctrl_after_rst",   4'h0, 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
